// File: rtl/single_wb_ctrl.sv
// Writeback controller: merges ALU results with FIFO-buffered late results onto the GPR write port.
// Optional WB_BYPASS_EN lets a late result skip the empty FIFO when the write port is idle.
module single_wb_ctrl #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_alu_wen,
    input  logic [AW-1:0] i_alu_reg,
    input  logic [DW-1:0] i_alu_data,
    output logic          o_alu_hold,
    input  logic          i_iss_en,
    input  logic [AW-1:0] i_iss_reg,
    input  logic          i_lr_valid,
    input  logic [AW-1:0] i_lr_reg,
    input  logic [DW-1:0] i_lr_data,
    output logic          o_lr_ready,
    input  logic [AW-1:0] i_qaddr1,
    input  logic [AW-1:0] i_qaddr2,
    output logic          o_stall,
    output logic [AW-1:0] o_wreg,
    output logic [DW-1:0] o_wdata,
    output logic          o_wen
);

    localparam int unsigned NREG = 2 ** AW;
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam int unsigned PW   = IW + 1;
    localparam int unsigned AGW  = $clog2(STARVE_MAX + 1);

    logic [AW-1:0]   r_mem_reg  [DEPTH];
    logic [DW-1:0]   r_mem_data [DEPTH];
    logic [PW-1:0]   r_wp, r_rp;
    logic [AGW-1:0]  r_age;
    logic [NREG-1:0] r_pend;
    logic [AW-1:0]   r_wreg;
    logic [DW-1:0]   r_wdata;
    logic            r_wen;

    logic [PW-1:0]   w_count;
    logic            w_empty, w_full, w_hold, w_lr_fire, w_push, w_pop, w_bypass;
    logic            w_sel_v;
    logic [AW-1:0]   w_sel_reg, w_head_reg;
    logic [DW-1:0]   w_sel_data, w_head_data;
    logic [AGW-1:0]  w_age_nxt;
    logic [NREG-1:0] w_pend_nxt;

    assign w_count     = r_wp - r_rp;
    assign w_empty     = (r_wp == r_rp);
    assign w_full      = (w_count == PW'(DEPTH));
    assign w_head_reg  = r_mem_reg[r_rp[IW-1:0]];
    assign w_head_data = r_mem_data[r_rp[IW-1:0]];
    assign w_hold      = (r_age == AGW'(STARVE_MAX)) && !w_empty;
    assign w_lr_fire   = i_lr_valid && o_lr_ready;

    assign o_lr_ready  = !w_full && !rst;
    assign o_alu_hold  = w_hold;
    assign o_stall     = r_pend[i_qaddr1] | r_pend[i_qaddr2];
    assign o_wreg      = r_wreg;
    assign o_wdata     = r_wdata;
    assign o_wen       = r_wen;

    // Write-port arbitration: starved head, then ALU, then FIFO drain, then bypass.
    always_comb begin
        w_pop      = 1'b0;
        w_bypass   = 1'b0;
        w_sel_v    = 1'b0;
        w_sel_reg  = '0;
        w_sel_data = '0;
        if (w_hold) begin
            w_pop      = 1'b1;
            w_sel_v    = 1'b1;
            w_sel_reg  = w_head_reg;
            w_sel_data = w_head_data;
        end else if (i_alu_wen) begin
            w_sel_v    = 1'b1;
            w_sel_reg  = i_alu_reg;
            w_sel_data = i_alu_data;
        end else if (!w_empty) begin
            w_pop      = 1'b1;
            w_sel_v    = 1'b1;
            w_sel_reg  = w_head_reg;
            w_sel_data = w_head_data;
`ifdef WB_BYPASS_EN
        end else if (w_lr_fire) begin
            w_bypass   = 1'b1;
            w_sel_v    = 1'b1;
            w_sel_reg  = i_lr_reg;
            w_sel_data = i_lr_data;
`endif
        end
    end

    assign w_push = w_lr_fire && (i_lr_reg != '0) && !w_bypass;

    // Scoreboard: a new issue overrides a same-cycle retire of the same register.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_pop)
            w_pend_nxt[w_head_reg] = 1'b0;
        if (w_bypass)
            w_pend_nxt[i_lr_reg] = 1'b0;
        if (i_iss_en && (i_iss_reg != '0))
            w_pend_nxt[i_iss_reg] = 1'b1;
    end

    always_comb begin
        w_age_nxt = r_age;
        if (w_empty || w_pop)
            w_age_nxt = '0;
        else if (r_age != AGW'(STARVE_MAX))
            w_age_nxt = r_age + AGW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_reg[r_wp[IW-1:0]]  <= i_lr_reg;
            r_mem_data[r_wp[IW-1:0]] <= i_lr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_age   <= '0;
            r_pend  <= '0;
            r_wen   <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + PW'(1);
            if (w_pop)
                r_rp <= r_rp + PW'(1);
            r_age  <= w_age_nxt;
            r_pend <= w_pend_nxt;
            r_wen  <= w_sel_v && (w_sel_reg != '0);
            if (w_sel_v) begin
                r_wreg  <= w_sel_reg;
                r_wdata <= w_sel_data;
            end
        end
    end

endmodule

// File: tb/tb_single_wb_ctrl.sv
// Directed self-checking bench for single_wb_ctrl (default and WB_BYPASS_EN builds).
module tb_single_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_alu_wen;
    logic [4:0]  i_alu_reg;
    logic [31:0] i_alu_data;
    logic        o_alu_hold;
    logic        i_iss_en;
    logic [4:0]  i_iss_reg;
    logic        i_lr_valid;
    logic [4:0]  i_lr_reg;
    logic [31:0] i_lr_data;
    logic        o_lr_ready;
    logic [4:0]  i_qaddr1, i_qaddr2;
    logic        o_stall;
    logic [4:0]  o_wreg;
    logic [31:0] o_wdata;
    logic        o_wen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    single_wb_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .i_alu_wen  (i_alu_wen),
        .i_alu_reg  (i_alu_reg),
        .i_alu_data (i_alu_data),
        .o_alu_hold (o_alu_hold),
        .i_iss_en   (i_iss_en),
        .i_iss_reg  (i_iss_reg),
        .i_lr_valid (i_lr_valid),
        .i_lr_reg   (i_lr_reg),
        .i_lr_data  (i_lr_data),
        .o_lr_ready (o_lr_ready),
        .i_qaddr1   (i_qaddr1),
        .i_qaddr2   (i_qaddr2),
        .o_stall    (o_stall),
        .o_wreg     (o_wreg),
        .o_wdata    (o_wdata),
        .o_wen      (o_wen)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and checks happen 1ns after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        i_alu_wen  = 1'b0; i_alu_reg = '0; i_alu_data = '0;
        i_iss_en   = 1'b0; i_iss_reg = '0;
        i_lr_valid = 1'b0; i_lr_reg  = '0; i_lr_data  = '0;
    endtask

    initial begin
        rst = 1'b1;
        i_qaddr1 = '0; i_qaddr2 = '0;
        idle();
        step(); step();
        chk("rst_wen", 64'(o_wen), 64'd0);
        chk("rst_wreg", 64'(o_wreg), 64'd0);
        chk("rst_wdata", 64'(o_wdata), 64'd0);
        chk("rst_ready", 64'(o_lr_ready), 64'd0);
        chk("rst_stall", 64'(o_stall), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(o_lr_ready), 64'd1);

        // 1: ALU write latency 1
        i_alu_wen = 1'b1; i_alu_reg = 5'd5; i_alu_data = 32'hDEADBEEF;
        step();
        idle();
        chk("t1_wen", 64'(o_wen), 64'd1);
        chk("t1_wreg", 64'(o_wreg), 64'd5);
        chk("t1_wdata", 64'(o_wdata), 64'hDEADBEEF);
        step();
        chk("t1_wen_off", 64'(o_wen), 64'd0);

        // 2: issue then late result to reg 7
        i_qaddr1 = 5'd7;
        i_iss_en = 1'b1; i_iss_reg = 5'd7;
        step();
        idle();
        #1;
        chk("t2_stall_set", 64'(o_stall), 64'd1);
        i_lr_valid = 1'b1; i_lr_reg = 5'd7; i_lr_data = 32'h1234;
        step();
        idle();
`ifdef WB_BYPASS_EN
        chk("t2_wen_byp", 64'(o_wen), 64'd1);
        chk("t2_wdata_byp", 64'(o_wdata), 64'h1234);
        chk("t2_stall_clr", 64'(o_stall), 64'd0);
`else
        chk("t2_wen_early", 64'(o_wen), 64'd0);
        chk("t2_stall_mid", 64'(o_stall), 64'd1);
        step();
        chk("t2_wen", 64'(o_wen), 64'd1);
        chk("t2_wreg", 64'(o_wreg), 64'd7);
        chk("t2_wdata", 64'(o_wdata), 64'h1234);
        chk("t2_stall_clr", 64'(o_stall), 64'd0);
`endif
        step();
        chk("t2_wen_off", 64'(o_wen), 64'd0);

        // 3: fill FIFO under continuous ALU writes, starvation hold, ordered drain
        i_alu_wen = 1'b1; i_alu_reg = 5'd1;
        for (int i = 0; i < 4; i++) begin
            i_alu_data = 32'(i);
            i_lr_valid = 1'b1; i_lr_reg = 5'(10 + i); i_lr_data = 32'hA0 + 32'(i);
            #1;
            chk("t3_ready_push", 64'(o_lr_ready), 64'd1);
            step();
            chk("t3_alu_wreg", 64'(o_wreg), 64'd1);
        end
        i_lr_valid = 1'b0;
        #1;
        chk("t3_full", 64'(o_lr_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_no_hold", 64'(o_alu_hold), 64'd0);
            step();
            chk("t3_alu_wins", 64'(o_wreg), 64'd1);
        end
        i_alu_data = 32'h99;
        chk("t3_hold", 64'(o_alu_hold), 64'd1);
        step();
        i_alu_wen = 1'b0;
        #1;
        chk("t3_head_wen", 64'(o_wen), 64'd1);
        chk("t3_head_reg", 64'(o_wreg), 64'd10);
        chk("t3_head_data", 64'(o_wdata), 64'hA0);
        chk("t3_hold_off", 64'(o_alu_hold), 64'd0);
        chk("t3_ready_again", 64'(o_lr_ready), 64'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("t3_drain_reg", 64'(o_wreg), 64'(10 + i));
            chk("t3_drain_data", 64'(o_wdata), 64'hA0 + 64'(i));
        end
        step();
        chk("t3_done", 64'(o_wen), 64'd0);

        // 4: register 0 is never written or tracked
        i_qaddr1 = '0; i_qaddr2 = '0;
        i_iss_en = 1'b1; i_iss_reg = '0;
        i_lr_valid = 1'b1; i_lr_reg = '0; i_lr_data = 32'h55;
        step();
        idle();
        chk("t4_stall0", 64'(o_stall), 64'd0);
        chk("t4_wen_a", 64'(o_wen), 64'd0);
        step();
        chk("t4_wen_b", 64'(o_wen), 64'd0);
        chk("t4_empty", 64'(o_alu_hold), 64'd0);

        // 5: reset discards queued entries and pending bits
        i_qaddr1 = 5'd3;
        i_iss_en = 1'b1; i_iss_reg = 5'd3;
        i_alu_wen = 1'b1; i_alu_reg = 5'd2; i_alu_data = 32'h77;
        for (int i = 0; i < 3; i++) begin
            i_lr_valid = 1'b1; i_lr_reg = 5'(3 + i); i_lr_data = 32'hB0 + 32'(i);
            step();
            i_iss_en = 1'b0;
        end
        i_lr_valid = 1'b0;
        #1;
        chk("t5_pend3", 64'(o_stall), 64'd1);
        rst = 1'b1;
        step();
        chk("t5_wen", 64'(o_wen), 64'd0);
        chk("t5_wreg", 64'(o_wreg), 64'd0);
        chk("t5_wdata", 64'(o_wdata), 64'd0);
        chk("t5_ready", 64'(o_lr_ready), 64'd0);
        chk("t5_stall", 64'(o_stall), 64'd0);
        rst = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_stale", 64'(o_wen), 64'd0);
        end
        chk("t5_ready_after", 64'(o_lr_ready), 64'd1);

        // 6: re-issue of reg 9 in the cycle its older entry pops keeps pend set
        i_qaddr1 = 5'd9;
        i_iss_en = 1'b1; i_iss_reg = 5'd9;
        step();
        idle();
        i_alu_wen = 1'b1; i_alu_reg = 5'd2; i_alu_data = 32'h5;
        i_lr_valid = 1'b1; i_lr_reg = 5'd9; i_lr_data = 32'hC9;
        step();
        idle();
        i_iss_en = 1'b1; i_iss_reg = 5'd9;
        step();
        idle();
        chk("t6_wen", 64'(o_wen), 64'd1);
        chk("t6_wreg", 64'(o_wreg), 64'd9);
        chk("t6_wdata", 64'(o_wdata), 64'hC9);
        chk("t6_stall", 64'(o_stall), 64'd1);
        step();
        chk("t6_stall_keep", 64'(o_stall), 64'd1);
        chk("t6_wen_off", 64'(o_wen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
